// File: rtl/bram_fifo_pkg.sv
// Shared widths and output-stage sizing for the BRAM-backed FWFT FIFO.
package bram_fifo_pkg;
  localparam int OSTAGE_DEPTH = 2;
  localparam int OCC_W = $clog2(OSTAGE_DEPTH + 1);
  localparam logic [OCC_W-1:0] OSTAGE_FULL = OCC_W'(OSTAGE_DEPTH);

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int cnt_w(input int aw);
    return aw + 2;
  endfunction
endpackage

// File: rtl/bram_fifo_ostage.sv
// Two-entry head/skid register that absorbs the BRAM read latency.
module bram_fifo_ostage
  import bram_fifo_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  input  logic              load,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] head,
  output logic [OCC_W-1:0]  occ
);
  logic [DWIDTH-1:0] skid;
  logic [OCC_W-1:0]  occ_ap;

  assign occ_ap = occ - {{(OCC_W-1){1'b0}}, pop};

  // Shift first, then the incoming word lands in the first free slot; the
  // later head assignment wins when both shift and load target the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
      occ  <= '0;
    end else begin
      if (pop) head <= skid;
      if (load) begin
        if (occ_ap == '0) head <= din;
        else              skid <= din;
      end
      occ <= occ_ap + {{(OCC_W-1){1'b0}}, load};
    end
  end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external simple dual-port BRAM.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DWIDTH-1:0]   s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DWIDTH-1:0]   m_data,
  output logic [AWIDTH+1:0]   count,
  output logic                mem_rce,
  output logic [AWIDTH-1:0]   mem_ra,
  input  logic [DWIDTH-1:0]   mem_rq,
  output logic                mem_wce,
  output logic [AWIDTH-1:0]   mem_wa,
  output logic [DWIDTH-1:0]   mem_wd
);
  localparam int PW = ptr_w(AWIDTH);
  localparam int CW = cnt_w(AWIDTH);
  localparam logic [PW-1:0] DEPTH   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [PW-1:0]    wr_ptr, rd_ptr, mem_cnt;
  logic             inflight;
  logic [OCC_W-1:0] oc, avail;
  logic             push, pop, issue;

  assign mem_cnt = wr_ptr - rd_ptr;
  assign s_ready = ~rst & (mem_cnt != DEPTH);
  assign push    = s_valid & s_ready;
  assign m_valid = (oc != '0);
  assign pop     = m_valid & m_ready;

  // Slots the output stage will hold next cycle; a new read is only worth
  // issuing if one will still be free when its data returns.
  assign avail = oc + {{(OCC_W-1){1'b0}}, inflight} - {{(OCC_W-1){1'b0}}, pop};
  assign issue = ~rst & (mem_cnt != '0) & (avail < OSTAGE_FULL);

  assign mem_wce = push;
  assign mem_wa  = wr_ptr[AWIDTH-1:0];
  assign mem_wd  = s_data;
  assign mem_rce = issue;
  assign mem_ra  = rd_ptr[AWIDTH-1:0];

  assign count = {1'b0, mem_cnt}
               + {{(CW-1){1'b0}}, inflight}
               + {{(CW-OCC_W){1'b0}}, oc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  bram_fifo_ostage #(.DWIDTH(DWIDTH)) u_ostage (
    .clk  (clk),
    .rst  (rst),
    .pop  (pop),
    .load (inflight),
    .din  (mem_rq),
    .head (m_data),
    .occ  (oc)
  );
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl (AWIDTH=4) with a behavioural BRAM beside it.
module tb_bram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [AW+1:0] count;
  logic          mem_rce, mem_wce;
  logic [AW-1:0] mem_ra, mem_wa;
  logic [DW-1:0] mem_rq, mem_wd;

  bram_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .mem_rce(mem_rce), .mem_ra(mem_ra), .mem_rq(mem_rq),
    .mem_wce(mem_wce), .mem_wa(mem_wa), .mem_wd(mem_wd)
  );

  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_wce) ram[mem_wa] <= mem_wd;
    if (mem_rce) mem_rq <= ram[mem_ra];
  end

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: captures accepted words into the expected queue, pops and
  // compares on every handshake, and tracks held/BRAM word counts.
  logic [DW-1:0] expq [$];
  int model_cnt = 0;
  int bram_words = 0;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      model_cnt  = 0;
      bram_words = 0;
      chk("rst_gate", {s_ready, mem_wce, mem_rce}, 3'b000);
    end else begin
      chk("count", count, model_cnt);
      if (mem_rce) chk("rce_nonempty", bram_words > 0, 1);
      if (mem_wce) chk("wce_notfull", bram_words < DEPTH, 1);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("pop_empty", 1, 0);
        else chk("data", m_data, expq.pop_front());
        model_cnt--;
      end
      if (s_valid && s_ready) begin
        expq.push_back(s_data);
        model_cnt++;
      end
      bram_words += int'(mem_wce) - int'(mem_rce);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n, cyc;

  initial begin
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h1111; m_ready = 1'b0;
    @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mdata", m_data, 0);
    step();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("sready_after_rst", s_ready, 1);

    // Single word latency
    step(); s_valid = 1'b1; s_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t0_wce_wa", {mem_wce, mem_wa}, {1'b1, 4'd0});
    chk("t0_wd", mem_wd, 32'hDEADBEEF);
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("t1_rce_ra", {mem_rce, mem_ra}, {1'b1, 4'd0});
    chk("t1_count", count, 1);
    step(); @(negedge clk);
    chk("t2_mvalid", m_valid, 0);
    step(); @(negedge clk);
    chk("t3_mvalid", m_valid, 1);
    chk("t3_mdata", m_data, 32'hDEADBEEF);
    step(); m_ready = 1'b1;
    step(); m_ready = 1'b0;
    @(negedge clk);
    chk("single_empty", {m_valid, count}, 0);

    // Fill with consumer stalled
    n = 0;
    for (int i = 0; i < 25; i++) begin
      step(); s_valid = 1'b1; s_data = n;
      @(negedge clk);
      if (s_ready) n++;
    end
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", n, DEPTH + 2);
    chk("fill_sready", s_ready, 0);
    chk("fill_count", count, DEPTH + 2);
    chk("fill_head", {m_valid, m_data}, {1'b1, 32'd0});

    // Drain: no bubbles
    step(); m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      chk("drain_valid", m_valid, 1);
      if (i == 2) chk("drain_sready", s_ready, 1);
      step();
    end
    @(negedge clk);
    chk("drain_done", {m_valid, count}, 0);

    // Streaming 100 words, 3-cycle latency then 1 word/cycle
    for (int i = 0; i < 103; i++) begin
      step(); s_valid = (i < 100); s_data = i; m_ready = 1'b1;
      @(negedge clk);
      chk("stream_valid", m_valid, i >= 3);
    end
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("stream_done", {m_valid, count}, 0);

    // Random backpressure on both sides
    n = 0; cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      step();
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (s_valid && s_ready) n++;
      cyc++;
    end
    chk("rand_words", n, 10000);
    step(); s_valid = 1'b0; m_ready = 1'b1;
    cyc = 0;
    while (count != 0 && cyc < 100) begin step(); cyc++; end
    chk("rand_drained", count, 0);

    // Reset mid-stream with 7 held and a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); s_valid = 1'b1; s_data = 100 + i;
    end
    step(); s_valid = 1'b0;
    step(); step(); step();
    m_ready = 1'b1;
    step(); m_ready = 1'b0;
    chk("pre_rst_count", count, 7);
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
    #1;
    chk("rst_mid_gate", {mem_rce, mem_wce, s_ready}, 3'b000);
    chk("rst_mid_state", {m_valid, count}, 0);
    step(); step();
    rst = 1'b0; s_data = 32'h5A; m_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {m_valid, count}, 0);
    step(); s_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("post_rst_head", {m_valid, m_data}, {1'b1, 32'h5A});
    step(); m_ready = 1'b1;
    step(); m_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", count, 0);
    chk("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
